// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debouncing and a one-cycle key strobe.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned DEB_CYCLES    = 20000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_pressed,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CntMax = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DivLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      col_meta_q, col_s_q;
  logic [3:0]      row_q, row_d;
  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      pat_q, pat_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      key_pressed_q, key_pressed_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;

  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic       one_low;
  logic [3:0] row_rot;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // Keypad layout; r selects the driven row, c the low column (c=0 leftmost).
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    unique case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_q <= 4'b1111;
      col_s_q    <= 4'b1111;
    end else begin
      col_meta_q <= col;
      col_s_q    <= col_meta_q;
    end
  end

  always_comb begin
    row_idx = 2'd0;
    unique case (row_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    one_low = 1'b1;
    col_idx = 2'd0;
    unique case (col_s_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign row_rot = {row_q[2:0], row_q[3]};

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    div_cnt_d     = div_cnt_q;
    cnt_d         = cnt_q;
    pat_d         = pat_q;
    cand_d        = cand_q;
    key_pressed_d = key_pressed_q;
    key_valid_d   = 1'b0;
    key_held_d    = key_held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d     = rep_cnt_q;
`endif

    unique case (state_q)
      StScan: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          if (one_low) begin
            cand_d  = key_code(row_idx, col_idx);
            pat_d   = col_s_q;
            cnt_d   = '0;
            state_d = StDebounce;
          end else begin
            row_d = row_rot;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      StDebounce: begin
        if (col_s_q == pat_q) begin
          if (cnt_q == DebLast) begin
            key_pressed_d = cand_q;
            key_valid_d   = 1'b1;
            key_held_d    = 1'b1;
            cnt_d         = '0;
            state_d       = StHeld;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_d     = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d   = StScan;
          row_d     = row_rot;
          div_cnt_d = '0;
        end
      end

      StHeld: begin
        if (col_s_q == 4'b1111) begin
          state_d = StRelease;
          cnt_d   = '0;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if (rep_cnt_q == RepLast) begin
            rep_cnt_d   = '0;
            key_valid_d = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
`endif
        end
      end

      StRelease: begin
        // Any bounce back to a low column restarts the release window.
        if (col_s_q == 4'b1111) begin
          if (cnt_q == DebLast) begin
            key_held_d = 1'b0;
            state_d    = StScan;
            row_d      = row_rot;
            div_cnt_d  = '0;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StScan;
      row_q         <= 4'b1110;
      div_cnt_q     <= '0;
      cnt_q         <= '0;
      pat_q         <= 4'b1111;
      cand_q        <= 4'h0;
      key_pressed_q <= 4'h0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      div_cnt_q     <= div_cnt_d;
      cnt_q         <= cnt_d;
      pat_q         <= pat_d;
      cand_q        <= cand_d;
      key_pressed_q <= key_pressed_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  assign row         = row_q;
  assign key_pressed = key_pressed_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner: a matrix keypad model drives col from row,
// expected codes are queued at press time and popped by a monitor on every key_valid strobe.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV      = 4;
  localparam int unsigned DEB_CYCLES    = 8;
  localparam int unsigned REPEAT_CYCLES = 32;
  localparam int          LatBudget     = 2 + 4 * SCAN_DIV + DEB_CYCLES + 1 + 8;

  localparam logic [3:0] LAYOUT [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_pressed;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int         checks  = 0;
  int         errors  = 0;
  int         strobes = 0;
  logic [3:0] exp_q [$];
  logic [3:0] mon_exp;

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; columns idle high.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEB_CYCLES    (DEB_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col         (col),
    .row         (row),
    .key_pressed (key_pressed),
    .key_valid   (key_valid),
    .key_held    (key_held)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && key_valid) begin
      strobes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got key %0h expected no strobe", key_pressed);
      end else begin
        mon_exp = exp_q.pop_front();
        check("strobe_code", {28'd0, key_pressed}, {28'd0, mon_exp});
        check("held_at_strobe", {31'd0, key_held}, 32'd1);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_strobe(input int target, input int budget);
    int n = 0;
    while (strobes < target && n < budget) begin
      cyc(1);
      n++;
    end
    check("strobe_latency", {31'd0, strobes >= target}, 32'd1);
  endtask

  task automatic wait_release(input int budget);
    int n = 0;
    while (key_held && n < budget) begin
      cyc(1);
      n++;
    end
    check("release_held", {31'd0, key_held}, 32'd0);
  endtask

  // Press (r,c), hold it for extra cycles past the first strobe, then release.
  task automatic press_release(input int r, input int c, input int extra);
    int base = strobes;
    int nexp = 1;
    int idx  = r * 4 + c;
`ifdef KEYPAD_AUTOREPEAT_EN
    nexp += extra / REPEAT_CYCLES;
`endif
    for (int i = 0; i < nexp; i++) exp_q.push_back(LAYOUT[idx]);
    keys[idx] = 1'b1;
    wait_strobe(base + 1, LatBudget);
    cyc(extra);
    keys[idx] = 1'b0;
    wait_release(40);
    check("strobe_count", strobes, base + nexp);
    check("code_kept", {28'd0, key_pressed}, {28'd0, LAYOUT[idx]});
    cyc(4);
  endtask

  task automatic check_reset_outputs();
    check("rst_row", {28'd0, row}, 32'hE);
    check("rst_key", {28'd0, key_pressed}, 32'h0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_held", {31'd0, key_held}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    cyc(3);
    check_reset_outputs();
    rst = 1'b1;
    cyc(5);

    // Single stable press of '6'
    press_release(1, 2, 3);

    // '*' bouncing for 40 cycles must not strobe, then a stable press does
    base = strobes;
    for (int i = 0; i < 8; i++) begin
      keys[12] = ~keys[12];
      cyc(5);
    end
    keys[12] = 1'b0;
    check("bounce_no_strobe", strobes, base);
    press_release(3, 0, 2);

    // Two keys on the same row never resolve to a code
    base = strobes;
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    cyc(200);
    check("multi_no_strobe", strobes, base);
    check("multi_not_held", {31'd0, key_held}, 32'd0);
    keys = '0;
    cyc(10);

    // 'D' held for 100 cycles past the first strobe
    press_release(3, 3, 100);

    // Asynchronous reset while '#' is held
    base = strobes;
    exp_q.push_back(LAYOUT[14]);
    keys[14] = 1'b1;
    wait_strobe(base + 1, LatBudget);
    cyc(3);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    cyc(3);
    check_reset_outputs();
    // Still held after reset: treated as a fresh press
    base = strobes;
    exp_q.push_back(LAYOUT[14]);
    rst = 1'b1;
    wait_strobe(base + 1, LatBudget);
    keys[14] = 1'b0;
    wait_release(40);
    cyc(4);
    press_release(3, 1, 0);

    // Randomized single presses
    repeat (8) begin
      press_release(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 20)));
    end

    cyc(10);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
